idex_dispatch_queue: RTL and testbench

- Sits between the decode stage and the reservation stations of the execution units.
- Decode pushes one renamed instruction per cycle: op, execution unit, two operand tag/value pairs, ROB target, pc, branch offset and access width.
- The block buffers instructions in order in a small circular queue, snoops the writeback (CDB) bus to resolve pending operand tags while waiting, and issues the head instruction when its unit's reservation station is not full.
- Absorbs RS-full back-pressure so decode stalls only when the queue itself is full.

---
 rtl/idex_dispatch_queue.sv | 168 ++++++++++++++++
 tb/tb_idex_dispatch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/idex_dispatch_queue.sv
// In-order dispatch buffer between decode and the reservation stations.
// Snoops the CDB to resolve operand tags while instructions wait for their unit's RS.
module idex_dispatch_queue #(
  parameter int COMMON_W    = 32,
  parameter int TAG_W       = 5,
  parameter int TAG_INVALID = 0,
  parameter int OP_W        = 6,
  parameter int UNIT_W      = 2,
  parameter int EX_UNIT_NUM = 4,
  parameter int ERR_UNIT    = 0,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on occupancy, out_valid is the issue strobe.
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [UNIT_W-1:0]        in_ex_unit,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_tag1,
  input  logic [TAG_W-1:0]         in_tag2,
  input  logic [COMMON_W-1:0]      in_val1,
  input  logic [COMMON_W-1:0]      in_val2,
  input  logic [TAG_W-1:0]         in_target,
  input  logic [COMMON_W-1:0]      in_pc,
  input  logic [COMMON_W-1:0]      in_offset,
  input  logic [2:0]               in_width,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [COMMON_W-1:0]      cdb_data,
  input  logic [EX_UNIT_NUM-1:0]   rs_full,
  output logic                     out_valid,
  output logic [UNIT_W-1:0]        out_ex_unit,
  output logic [OP_W-1:0]          out_op,
  output logic [TAG_W-1:0]         out_tag1,
  output logic [TAG_W-1:0]         out_tag2,
  output logic [COMMON_W-1:0]      out_val1,
  output logic [COMMON_W-1:0]      out_val2,
  output logic [TAG_W-1:0]         out_target,
  output logic [COMMON_W-1:0]      out_pc,
  output logic [COMMON_W-1:0]      out_offset,
  output logic [2:0]               out_width,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0]  TAG_NONE = TAG_W'(TAG_INVALID);
  localparam logic [UNIT_W-1:0] UNIT_ERR = UNIT_W'(ERR_UNIT);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [UNIT_W-1:0]   ex_unit;
    logic [OP_W-1:0]     op;
    logic [TAG_W-1:0]    tag1;
    logic [TAG_W-1:0]    tag2;
    logic [COMMON_W-1:0] val1;
    logic [COMMON_W-1:0] val2;
    logic [TAG_W-1:0]    target;
    logic [COMMON_W-1:0] pc;
    logic [COMMON_W-1:0] offset;
    logic [2:0]          width;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t head_e;
  entry_t in_e;
  logic   cdb_hit;
  logic   enq, store, deq;

  // Applies a live CDB broadcast to an entry's operands.
  function automatic entry_t resolve(input entry_t e, input logic hit,
                                     input logic [TAG_W-1:0] tag,
                                     input logic [COMMON_W-1:0] data);
    entry_t r;
    r = e;
    if (hit && e.tag1 == tag) begin
      r.tag1 = TAG_NONE;
      r.val1 = data;
    end
    if (hit && e.tag2 == tag) begin
      r.tag2 = TAG_NONE;
      r.val2 = data;
    end
    return r;
  endfunction

  always_comb begin
    cdb_hit = cdb_valid && (cdb_tag != TAG_NONE);
    in_e    = '{ex_unit: in_ex_unit, op: in_op, tag1: in_tag1, tag2: in_tag2,
                val1: in_val1, val2: in_val2, target: in_target, pc: in_pc,
                offset: in_offset, width: in_width};
    head_e  = resolve(mem_q[head_q], cdb_hit, cdb_tag, cdb_data);

    in_ready  = (count_q < CNT_FULL);
    out_valid = (count_q != '0) && !rs_full[head_e.ex_unit] && !flush;
    enq       = in_valid && in_ready && !flush;
    store     = enq && (in_ex_unit != UNIT_ERR);
    deq       = out_valid;

    out_ex_unit = head_e.ex_unit;
    out_op      = head_e.op;
    out_tag1    = head_e.tag1;
    out_tag2    = head_e.tag2;
    out_val1    = head_e.val1;
    out_val2    = head_e.val2;
    out_target  = head_e.target;
    out_pc      = head_e.pc;
    out_offset  = head_e.offset;
    out_width   = head_e.width;
    count       = count_q;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      // Unoccupied slots are snooped too; their contents are never observed.
      mem_d[i] = resolve(mem_q[i], cdb_hit, cdb_tag, cdb_data);
    end
    if (store) begin
      mem_d[tail_q] = resolve(in_e, cdb_hit, cdb_tag, cdb_data);
      tail_d        = tail_q + PTR_W'(1);
    end
    if (deq) head_d = head_q + PTR_W'(1);
    case ({store, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].tag1 = TAG_NONE;
        mem_d[i].tag2 = TAG_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]      <= '0;
        mem_q[i].tag1 <= TAG_NONE;
        mem_q[i].tag2 <= TAG_NONE;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_idex_dispatch_queue.sv
// Randomized bench for idex_dispatch_queue against a queue-based reference model.
module tb_idex_dispatch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  unit;
    logic [5:0]  op;
    logic [4:0]  t1;
    logic [4:0]  t2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  tgt;
    logic [31:0] pc;
    logic [31:0] off;
    logic [2:0]  w;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  ent_t        in_e = '0;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic [3:0]  rs_full = '0;
  logic        out_valid;
  logic [1:0]  out_ex_unit;
  logic [5:0]  out_op;
  logic [4:0]  out_tag1, out_tag2, out_target;
  logic [31:0] out_val1, out_val2, out_pc, out_offset;
  logic [2:0]  out_width;
  logic [2:0]  count;

  ent_t ref_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  idex_dispatch_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ex_unit(in_e.unit), .in_op(in_e.op),
    .in_tag1(in_e.t1), .in_tag2(in_e.t2),
    .in_val1(in_e.v1), .in_val2(in_e.v2),
    .in_target(in_e.tgt), .in_pc(in_e.pc),
    .in_offset(in_e.off), .in_width(in_e.w),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rs_full(rs_full),
    .out_valid(out_valid), .out_ex_unit(out_ex_unit), .out_op(out_op),
    .out_tag1(out_tag1), .out_tag2(out_tag2),
    .out_val1(out_val1), .out_val2(out_val2),
    .out_target(out_target), .out_pc(out_pc),
    .out_offset(out_offset), .out_width(out_width),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // A broadcast with a non-zero tag marks matching operands ready with its data.
  function automatic ent_t wake(input ent_t e);
    ent_t r;
    r = e;
    if (cdb_valid && cdb_tag != 0) begin
      if (r.t1 == cdb_tag) begin r.t1 = 0; r.v1 = cdb_data; end
      if (r.t2 == cdb_tag) begin r.t2 = 0; r.v2 = cdb_data; end
    end
    return r;
  endfunction

  // Called just after inputs change at a negedge: checks outputs, advances the
  // model to the state after the coming posedge, then waits for the next negedge.
  task automatic step();
    ent_t h;
    logic exp_v;
    #1;
    exp_v = 1'b0;
    check("count", count, ref_q.size());
    check("in_ready", in_ready, ref_q.size() < DEPTH);
    if (ref_q.size() != 0) begin
      h = wake(ref_q[0]);
      exp_v = !rs_full[h.unit] && !flush;
      check("out_ex_unit", out_ex_unit, h.unit);
      check("out_op", out_op, h.op);
      check("out_tag1", out_tag1, h.t1);
      check("out_tag2", out_tag2, h.t2);
      check("out_val1", out_val1, h.v1);
      check("out_val2", out_val2, h.v2);
      check("out_target", out_target, h.tgt);
      check("out_pc", out_pc, h.pc);
      check("out_offset", out_offset, h.off);
      check("out_width", out_width, h.w);
    end
    check("out_valid", out_valid, exp_v);
    if (flush) begin
      ref_q.delete();
    end else begin
      bit accept;
      accept = in_valid && ref_q.size() < DEPTH;
      foreach (ref_q[i]) ref_q[i] = wake(ref_q[i]);
      if (exp_v) void'(ref_q.pop_front());
      if (accept && in_e.unit != 0) ref_q.push_back(wake(in_e));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] unit, input logic [4:0] t1, input logic [31:0] v1,
                      input logic [4:0] t2, input logic [31:0] v2);
    in_valid = 1'b1;
    in_e.unit = unit; in_e.op = 6'($urandom); in_e.t1 = t1; in_e.v1 = v1;
    in_e.t2 = t2; in_e.v2 = v2; in_e.tgt = 5'($urandom); in_e.pc = $urandom;
    in_e.off = $urandom; in_e.w = 3'($urandom);
  endtask

  initial begin
    #12 rst = 1'b0;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tag1", out_tag1, 0);
    check("rst_out_val1", out_val1, 0);
    check("rst_out_pc", out_pc, 0);

    // Basic push and issue on the next cycle.
    push(2'd1, 5'd0, 32'd5, 5'd0, 32'd7); step();
    idle(); step();
    step();

    // Operand woken while waiting, then woken in the issue cycle by bypass.
    rs_full = 4'b1111;
    push(2'd1, 5'd3, 32'h1, 5'd0, 32'h2); step();
    idle(); step();
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'hDEAD; step();
    idle(); rs_full = '0; step();
    push(2'd3, 5'd9, 32'h0, 5'd0, 32'h4); rs_full = 4'b1000; step();
    idle(); rs_full = '0; cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'hDEAD; step();
    idle(); step();

    // Fill behind a full RS, refuse the fifth, then drain with pointer wrap.
    rs_full = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      push(2'd2, 5'd0, 32'(i), 5'd0, 32'(i + 10)); step();
    end
    idle(); rs_full = '0;
    for (int i = 0; i < 5; i++) step();

    // Illegal unit is consumed without being stored.
    push(2'd0, 5'd0, 32'd1, 5'd0, 32'd2); step();
    idle(); step();

    // Flush with three queued and a simultaneous push.
    rs_full = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      push(2'd1, 5'd4, 32'(i), 5'd5, 32'(i)); step();
    end
    flush = 1'b1; push(2'd2, 5'd0, 32'd1, 5'd0, 32'd1); step();
    idle(); rs_full = '0; step();

    // Asynchronous reset between edges.
    rs_full = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      push(2'd3, 5'd0, 32'(i), 5'd0, 32'(i)); step();
    end
    idle(); rs_full = '0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    ref_q.delete();
    #1 rst = 1'b0;
    @(negedge clk);

    // Random traffic with small tag space so CDB hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_e.unit = 2'($urandom_range(0, 3));
      in_e.op   = 6'($urandom);
      in_e.t1   = 5'($urandom_range(0, 7));
      in_e.t2   = 5'($urandom_range(0, 7));
      in_e.v1   = $urandom;
      in_e.v2   = $urandom;
      in_e.tgt  = 5'($urandom);
      in_e.pc   = $urandom;
      in_e.off  = $urandom;
      in_e.w    = 3'($urandom);
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_tag   = 5'($urandom_range(0, 7));
      cdb_data  = $urandom;
      rs_full   = 4'($urandom) & 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
